if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction fetch unit: the producer that feeds the if_id stage register.
//  - Owns the PC and drives a pipelined instruction-bus read initiator (req/gnt/rvalid).
//  - Buffers returned words in a small in-order prefetch FIFO.
//  - Presents the FIFO head to if_id as inst_o/inst_addr_o, stalling under hold and
//    flushing on jump.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset; first fetch address.
//  FIFO_DEPTH  4      prefetch entries, power of 2, >=2; also caps outstanding requests.
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous reset, active-high
//  jump_flag_i    in   1   redirect request from execute
//  jump_addr_i    in   32  redirect target, word aligned
//  hold_flag_i    in   3   pipeline hold code; fetch stalls when >= 3'b010
//  ibus_req_o     out  1   bus read request
//  ibus_addr_o    out  32  bus read address (= fetch PC)
//  ibus_gnt_i     in   1   request accepted this cycle
//  ibus_rvalid_i  in   1   read data valid, in order, one per granted request
//  ibus_rdata_i   in   32  read data
//  inst_o         out  32  instruction to if_id; 32'h00000001 (NOP) when not valid
//  inst_addr_o    out  32  address of inst_o; 32'h0 when not valid
//  inst_valid_o   out  1   inst_o holds a real fetched instruction
// BEHAVIOUR
//  Reset (async, immediate):
//   - fetch_pc=RESET_PC, resp_pc=RESET_PC.
//   - FIFO empty, outstanding=0, discard=0.
//   - ibus_req_o=0, ibus_addr_o=RESET_PC, inst_o=32'h1, inst_addr_o=0, inst_valid_o=0.
//  Issue:
//   - ibus_req_o=1 when outstanding + fifo_count < FIFO_DEPTH, or when a request is
//     already pending. First req is in the first clock after rst deasserts.
//   - ibus_addr_o=fetch_pc. On req&&gnt: fetch_pc+=4, outstanding+=1.
//   - A raised req is never withdrawn and its addr never changes until gnt, including
//     across a jump.
//   - Back-to-back grants are legal (one per cycle).
//  Response:
//   - Each rvalid: outstanding-=1.
//   - If discard>0: discard-=1 and the data is dropped.
//   - Else: push {ibus_rdata_i, resp_pc} into the FIFO; resp_pc+=4.
//   - The credit rule guarantees the FIFO never overflows; an rvalid when full is a bus
//     protocol error, checked by an assertion.
//  Output:
//   - When the FIFO is non-empty: inst_valid_o=1, inst_o/inst_addr_o = head.
//   - Otherwise: inst_valid_o=0, inst_o=32'h1, inst_addr_o=0 (combinational from FIFO
//     state).
//   - Latency: rvalid in cycle N -> inst_valid_o in N+1 (no bypass).
//  Hold:
//   - hold_en = (hold_flag_i >= 3'b010).
//   - Pop head at clock edge iff valid && !hold_en && !jump_flag_i.
//   - Under hold, outputs stay stable; fetching continues until credits run out.
//  Jump (priority over hold and over every other event in the same cycle):
//   - Same cycle: inst_valid_o forced 0, inst_o=32'h1, inst_addr_o=0.
//   - At the edge: FIFO cleared; fetch_pc=jump_addr_i and resp_pc=jump_addr_i, except
//     that a pending ungranted request keeps its addr until gnt and fetch_pc loads
//     jump_addr_i after that gnt.
//   - discard = outstanding after this edge, i.e. outstanding + (req&&gnt) - rvalid, plus
//     1 for a pending ungranted request. An rvalid in the jump cycle is dropped.
//   - Back-to-back jumps: each recomputes discard from the current in-flight total; only
//     the last target survives.
//  Widths: PC arithmetic mod 2^32; 32'hFFFFFFFC+4 wraps to 0. Counters sized
//   $clog2(FIFO_DEPTH)+1; outstanding and discard never exceed FIFO_DEPTH.
// TESTING
//  1 Reset release, gnt tied 1, rvalid one cycle after gnt with data=addr^32'hA5A5A5A5
//    -> addrs 0,4,8,...; inst_valid_o first high 2 cycles after the first gnt; stream
//    in order.
//  2 hold_flag_i=3'b010 for 10 cycles mid-stream -> inst_o/inst_addr_o frozen; exactly
//    FIFO_DEPTH words buffered; req drops; no loss or duplicate after release.
//  3 jump_flag_i=1, jump_addr_i=32'h100 with 2 requests outstanding -> both responses
//    dropped; next valid inst_addr_o=32'h100; no stale inst_o reaches if_id.
//  4 gnt held 0 for 5 cycles while req=1, jump to 32'h200 in cycle 2 -> ibus_addr_o
//    unchanged until gnt; that response discarded; next issued addr=32'h200.
//  5 rst asserted mid-stream, async between edges -> all outputs at reset values
//    immediately; fetch restarts at RESET_PC; later late rvalids ignored (bench models
//    bus reset too).
//  6 Random gnt/rvalid latency, random hold and jumps vs reference PC model -> inst/addr
//    sequence matches; no FIFO overflow assertion fires.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-bus read channel between fetch (master) and memory (slave).
// Pipelined req/gnt issue, in-order rvalid/rdata return, one beat per grant.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues pipelined bus reads, buffers replies
// in an in-order prefetch FIFO and presents the head to if_id.
// Ports: clk, rst (async, active-high), jump_flag_i/jump_addr_i redirect,
// hold_flag_i stall code, ibus (master read channel),
// inst_o/inst_addr_o/inst_valid_o towards if_id.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [2:0]        hold_flag_i,
  if_fetch_if.master        ibus,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o,
  output logic              inst_valid_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   jump_tgt;
  logic          jump_pend;
  logic          req_pend;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   addr_mem [FIFO_DEPTH];

  logic          hold_en;
  logic          empty;
  logic          credit;
  logic          req;
  logic          fire;
  logic          drop;
  logic          push;
  logic          valid;
  logic          pop;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] disc_nxt;

  always_comb begin
    hold_en = hold_flag_i >= 3'b010;
    empty   = count == '0;
    // In-flight replies plus buffered words may never exceed the FIFO,
    // so every reply always has a slot.
    credit  = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_X;
    // A raised request stays up until granted, credit or not.
    req     = !rst && (req_pend || credit);
    fire    = req && ibus.gnt;
    drop    = ibus.rvalid && (jump_flag_i || discard != '0);
    push    = ibus.rvalid && !drop;
    valid   = !empty && !jump_flag_i;
    pop     = valid && !hold_en;
    out_nxt = outstanding + CW'(fire) - CW'(ibus.rvalid);
    disc_nxt = discard;
    if (jump_flag_i) begin
      // Everything still in flight after this edge belongs to the old
      // stream, including a request that is up but not yet granted.
      disc_nxt = out_nxt + CW'(req && !ibus.gnt);
    end else if (ibus.rvalid && discard != '0) begin
      disc_nxt = discard - CW'(1);
    end
  end

  assign ibus.req     = req;
  assign ibus.addr    = fetch_pc;
  assign inst_valid_o = valid;
  assign inst_o       = valid ? data_mem[rd_ptr] : 32'h1;
  assign inst_addr_o  = valid ? addr_mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      jump_tgt    <= RESET_PC;
      jump_pend   <= 1'b0;
      req_pend    <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      req_pend    <= req && !ibus.gnt;
      if (fire) begin
        jump_pend <= 1'b0;
        if (jump_flag_i) begin
          fetch_pc <= jump_addr_i;
        end else if (jump_pend) begin
          fetch_pc <= jump_tgt;
        end else begin
          fetch_pc <= fetch_pc + 32'd4;
        end
      end else if (jump_flag_i) begin
        // An ungranted request must keep its address; park the target
        // until that grant arrives.
        if (req) begin
          jump_pend <= 1'b1;
          jump_tgt  <= jump_addr_i;
        end else begin
          jump_pend <= 1'b0;
          fetch_pc  <= jump_addr_i;
        end
      end
      if (jump_flag_i) begin
        resp_pc <= jump_addr_i;
      end else if (push) begin
        resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (jump_flag_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= ibus.rdata;
      addr_mem[wr_ptr] <= resp_pc;
    end
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst) push |-> count != FULL
  );

  a_rvalid_owed : assert property (
    @(posedge clk) disable iff (rst) ibus.rvalid |-> outstanding != '0
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: bus slave model, scoreboard of expected instructions,
// hold-decode vector table and directed jump/stall/reset sequences.
module tb_if_fetch;

  localparam int          D = 4;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic [2:0]  hold = 3'd0;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  if_fetch_if ibus ();

  if_fetch #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold),
    .ibus         (ibus),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } fl_t;

  typedef struct {
    logic [2:0] hold;
    bit         pop;
  } hvec_t;

  fl_t         infl[$];
  logic [31:0] sb[$];
  logic [31:0] mfpc;
  logic [31:0] mjtgt;
  bit          mjpend;
  bit          mstale_next;
  bit          mpend;
  int          cyc;
  int          checks;
  int          failures;
  int          pops;
  int          gnt_mode;
  int          lat_min;
  int          lat_max;
  bit          rv_rand;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    sb.delete();
    mfpc        = 32'h0;
    mjtgt       = 32'h0;
    mjpend      = 1'b0;
    mstale_next = 1'b0;
    mpend       = 1'b0;
  endtask

  task automatic drive_bus();
    case (gnt_mode)
      0:       ibus.gnt = 1'b0;
      1:       ibus.gnt = 1'b1;
      default: ibus.gnt = $urandom_range(2, 0) != 0;
    endcase
    ibus.rvalid = 1'b0;
    ibus.rdata  = 32'hDEADBEEF;
    if (infl.size() > 0 && infl[0].due <= cyc &&
        (!rv_rand || $urandom_range(3, 0) != 0)) begin
      ibus.rvalid = 1'b1;
      ibus.rdata  = infl[0].addr ^ K;
    end
  endtask

  // Check outputs mid-cycle, then advance the reference model across
  // the coming edge.
  task automatic mid_check();
    logic r;
    logic g;
    bit   ev;
    int   lat;
    fl_t  e;
    r  = ibus.req;
    g  = r && ibus.gnt;
    ev = sb.size() > 0 && !jump_flag;
    chk("ibus_addr", ibus.addr, mfpc);
    if (mpend) chk("req_held", 32'(r), 32'd1);
    chk("inst_valid", 32'(inst_valid), 32'(ev));
    if (ev) begin
      chk("inst_addr", inst_addr, sb[0]);
      chk("inst_data", inst, sb[0] ^ K);
    end else begin
      chk("nop_inst", inst, 32'h1);
      chk("nop_addr", inst_addr, 32'h0);
    end
    if (jump_flag) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      sb.delete();
    end else if (sb.size() > 0 && hold < 3'd2) begin
      void'(sb.pop_front());
      pops++;
    end
    if (ibus.rvalid) begin
      e = infl.pop_front();
      if (!e.stale) sb.push_back(e.addr);
    end
    if (g) begin
      lat = (lat_min == lat_max) ? lat_min
                                 : int'($urandom_range(lat_max, lat_min));
      infl.push_back('{addr: mfpc, stale: jump_flag || mstale_next,
                       due: cyc + lat});
      mstale_next = 1'b0;
      if (jump_flag)   mfpc = jump_addr;
      else if (mjpend) mfpc = mjtgt;
      else             mfpc = mfpc + 32'd4;
      mjpend = 1'b0;
    end else if (jump_flag) begin
      if (r) begin
        mjpend      = 1'b1;
        mjtgt       = jump_addr;
        mstale_next = 1'b1;
      end else begin
        mfpc = jump_addr;
      end
    end
    mpend = r && !ibus.gnt;
  endtask

  task automatic cycle();
    drive_bus();
    @(negedge clk);
    if (!rst) mid_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !inst_valid; i++) cycle();
  endtask

  initial begin
    hvec_t hv[10];
    int    first_v;
    logic [31:0] a;

    hv[0] = '{3'd2, 1'b0};
    hv[1] = '{3'd0, 1'b1};
    hv[2] = '{3'd3, 1'b0};
    hv[3] = '{3'd1, 1'b1};
    hv[4] = '{3'd7, 1'b0};
    hv[5] = '{3'd4, 1'b0};
    hv[6] = '{3'd0, 1'b1};
    hv[7] = '{3'd5, 1'b0};
    hv[8] = '{3'd6, 1'b0};
    hv[9] = '{3'd1, 1'b1};

    checks = 0; failures = 0; pops = 0; cyc = 0;
    gnt_mode = 0; lat_min = 1; lat_max = 1; rv_rand = 1'b0;
    ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = 32'h0;
    model_reset();

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 32'(ibus.req), 32'd0);
    chk("rst_addr", ibus.addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h1);
    chk("rst_iaddr", inst_addr, 32'h0);

    // 1: streaming from reset, latency 1
    rst = 1'b0;
    gnt_mode = 1;
    #1;
    chk("first_req", 32'(ibus.req), 32'd1);
    first_v = -1;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid && first_v < 0) first_v = i;
      cycle();
    end
    chk("first_valid_lat", 32'(first_v), 32'd2);

    // 2: hold for 10 cycles, credits run out and req drops
    hold = 3'd2;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("hold_req_drop", 32'(ibus.req), 32'd0);
      cycle();
    end
    hold = 3'd0;
    for (int i = 0; i < 15; i++) cycle();

    // hold-code decode table
    hold = 3'd2;
    for (int i = 0; i < 3; i++) cycle();
    foreach (hv[i]) begin
      if (sb.size() == 0) begin
        chk("tbl_nonempty", 32'd0, 32'd1);
      end else begin
        a    = sb[0];
        hold = hv[i].hold;
        cycle();
        chk("tbl_hold", inst_addr, a + (hv[i].pop ? 32'd4 : 32'd0));
      end
    end
    hold = 3'd0;

    // 3: jump with replies outstanding
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) cycle();
    chk("jmp_inflight", 32'(infl.size() >= 2), 32'd1);
    jump_flag = 1'b1; jump_addr = 32'h100;
    #1;
    chk("jmp_kill_valid", 32'(inst_valid), 32'd0);
    chk("jmp_kill_inst", inst, 32'h1);
    cycle();
    jump_flag = 1'b0;
    wait_valid(30);
    chk("jmp_target", inst_addr, 32'h100);
    chk("jmp_target_data", inst, 32'h100 ^ K);

    // wrap-around through 0
    lat_min = 1; lat_max = 1;
    jump_flag = 1'b1; jump_addr = 32'hFFFFFFF8;
    cycle();
    jump_flag = 1'b0;
    wait_valid(30);
    chk("wrap0", inst_addr, 32'hFFFFFFF8);
    cycle();
    chk("wrap1", inst_addr, 32'hFFFFFFFC);
    cycle();
    chk("wrap2", inst_addr, 32'h0);
    for (int i = 0; i < 8; i++) cycle();

    // 4: jump while a request waits for grant
    gnt_mode = 0;
    chk("stall_req", 32'(ibus.req), 32'd1);
    a = ibus.addr;
    cycle(); cycle();
    jump_flag = 1'b1; jump_addr = 32'h200;
    cycle();
    jump_flag = 1'b0;
    cycle(); cycle();
    chk("stall_addr_kept", ibus.addr, mfpc);
    gnt_mode = 1;
    cycle();
    chk("pend_next_req", 32'(ibus.req), 32'd1);
    chk("pend_next_addr", ibus.addr, 32'h200);
    wait_valid(30);
    chk("pend_first_inst", inst_addr, 32'h200);
    for (int i = 0; i < 6; i++) cycle();

    // 5: async reset between edges mid-stream
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 6; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(ibus.req), 32'd0);
    chk("arst_addr", ibus.addr, 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'h1);
    chk("arst_iaddr", inst_addr, 32'h0);
    model_reset();
    ibus.gnt = 1'b0; ibus.rvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("restart_req", 32'(ibus.req), 32'd1);
    chk("restart_addr", ibus.addr, 32'h0);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 15; i++) cycle();

    // 6: random grant/latency, holds and jumps
    gnt_mode = 2; lat_min = 1; lat_max = 4; rv_rand = 1'b1;
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      hold = ($urandom_range(9, 0) < 3) ? 3'($urandom_range(7, 2))
                                       : 3'($urandom_range(1, 0));
      jump_flag = $urandom_range(29, 0) == 0;
      jump_addr = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFF8
                                              : ($urandom() & 32'hFFFFFFFC);
      cycle();
    end
    jump_flag = 1'b0; hold = 3'd0;
    gnt_mode = 1; rv_rand = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("rand_progress", 32'(pops > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
